// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 16550-style UART transmit serializer.
// Pops bytes from the TX FIFO and shifts out start, 5-8 data bits (LSB
// first), optional parity and 1/1.5/2 stop bits, timed by an oversampled
// baud strobe. Line-control fields are captured at pop time so that
// mid-frame LCR writes only affect the next frame.
module uart_tx_engine #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       brk,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_empty,
  output logic       frame_done
);

  // Tick counter must reach 2*OVERSAMPLE for a two-stop-bit STOP state.
  localparam int TW = $clog2(2 * OVERSAMPLE + 1);

  localparam logic [TW-1:0] LEN_ONE = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] LEN_1P5 = TW'(OVERSAMPLE * 3 / 2);
  localparam logic [TW-1:0] LEN_TWO = TW'(2 * OVERSAMPLE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Per-frame line control, frozen when the byte is popped. The parity
  // bit is resolved at latch time so eps/sp need not be kept.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       par_bit;
  } frame_cfg_t;

  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  frame_cfg_t    cfg;
  frame_cfg_t    cfg_new;
  logic          tx_q;
  logic          done_q;

  logic [7:0]    data_mask;
  logic [TW-1:0] bit_len;
  logic          bit_end;
  logic          last_data;

  // Capture-side decode: word mask and parity of the head byte as it
  // will actually be transmitted (bits above the word length excluded).
  always_comb begin
    data_mask = 8'h1F;
    case (wls)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    cfg_new.wls     = wls;
    cfg_new.stb     = stb;
    cfg_new.pen     = pen;
    // Even parity = XOR of data bits; odd inverts it; stick forces ~eps.
    cfg_new.par_bit = sp ? ~eps : ((^(fifo_dout & data_mask)) ^ ~eps);
  end

  // Length of the current bit in baud ticks and end-of-bit detection.
  always_comb begin
    bit_len = LEN_ONE;
    if (state == S_STOP) begin
      if (!cfg.stb)             bit_len = LEN_ONE;
      else if (cfg.wls == 2'b00) bit_len = LEN_1P5;
      else                      bit_len = LEN_TWO;
    end
    bit_end   = baud_pulse && (state != S_IDLE) && (tick_cnt == bit_len - 1'b1);
    last_data = (bit_cnt == ({1'b0, cfg.wls} + 3'd4));
  end

  // Pop only from IDLE with data present, and never while held in reset.
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty && !rst;
  assign tx         = brk ? 1'b0 : tx_q;
  assign tx_busy    = (state != S_IDLE);
  assign tx_empty   = (state == S_IDLE) && fifo_empty;
  assign frame_done = done_q;

  // Baud tick counter: restarts on every bit boundary, idle while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || bit_end) begin
      tick_cnt <= '0;
    end else if (baud_pulse) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame sequencer; tx_q is loaded with the bit of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      cfg       <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_dout;
            cfg       <= cfg_new;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q  <= shift_reg[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (last_data) begin
              if (cfg.pen) begin
                tx_q  <= cfg.par_bit;
                state <= S_PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_q      <= shift_reg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tx_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: per-clock comparison of the UART line against a
// tick-level frame model. Each frame is expanded into a list of line
// values, one entry per baud tick; the expected tx at any clock is the
// entry indexed by the number of baud ticks seen since the pop.
module tb_uart_tx_engine;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, brk;
  logic       tx, tx_busy, tx_empty, frame_done;

  uart_tx_engine #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .brk(brk),
    .tx(tx), .tx_busy(tx_busy), .tx_empty(tx_empty), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO contents and frame model state
  logic [7:0] fq[$];
  logic       frame_bits[$];
  bit         m_active = 0;
  bit         m_done = 0;
  int         n = 0;
  int         cyc = 0;
  int         obs_pops = 0;
  int         obs_dones = 0;
  int         pop_cyc[$];
  bit         baud_rand = 0;
  bit         lcr_rand = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expand one byte under the current line control into per-tick line values.
  function automatic void build_frame(input logic [7:0] b);
    int nb;
    int ones;
    int stop_t;
    logic p;
    nb = int'(wls) + 5;
    ones = 0;
    frame_bits.delete();
    repeat (OS) frame_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (OS) frame_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (pen) begin
      if (sp)       p = ~eps;
      else if (eps) p = (ones % 2 == 1);
      else          p = (ones % 2 == 0);
      repeat (OS) frame_bits.push_back(p);
    end
    stop_t = !stb ? OS : (nb == 5 ? OS * 3 / 2 : 2 * OS);
    repeat (stop_t) frame_bits.push_back(1'b1);
  endfunction

  function automatic void drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  // One clock: check outputs at negedge, advance model at posedge, drive at +1.
  task automatic step();
    bit exp_pop;
    bit line;
    bit baud_at_edge;
    @(negedge clk);
    exp_pop = !m_active && (fq.size() != 0) && !rst;
    line    = m_active ? frame_bits[n] : 1'b1;
    chk("tx", tx, brk ? 1'b0 : line);
    chk("fifo_pop", fifo_pop, exp_pop);
    chk("tx_busy", tx_busy, m_active);
    chk("tx_empty", tx_empty, !m_active && (fq.size() == 0));
    chk("frame_done", frame_done, m_done);
    if (fifo_pop) begin obs_pops++; pop_cyc.push_back(cyc); end
    if (frame_done) obs_dones++;
    baud_at_edge = baud_pulse;
    @(posedge clk);
    cyc++;
    m_done = 0;
    if (rst) begin
      m_active = 0;
    end else if (m_active) begin
      if (baud_at_edge) n++;
      if (n == frame_bits.size()) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (exp_pop) begin
      build_frame(fq.pop_front());
      n = 0;
      m_active = 1;
    end
    #1;
    baud_pulse = baud_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    if (lcr_rand && m_active)
      set_lcr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
    drive_fifo();
  endtask

  task automatic run_idle(input int max_cyc);
    int c;
    c = 0;
    while ((m_active || fq.size() != 0 || m_done) && c < max_cyc) begin
      step();
      c++;
    end
    chk("drained_in_time", (c < max_cyc), 1);
    repeat (2) step();
  endtask

  task automatic send_one(input logic [7:0] b, input string tag, input int pops_exp);
    int p0, d0;
    p0 = obs_pops; d0 = obs_dones;
    fq.push_back(b);
    drive_fifo();
    run_idle(2000);
    chk({tag, "_pops"}, obs_pops - p0, pops_exp);
    chk({tag, "_dones"}, obs_dones - d0, pops_exp);
  endtask

  initial begin
    int p0, d0;
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;
    rst = 1'b1; baud_pulse = 1'b1; brk = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_fifo();
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_empty", tx_empty, 1'b1);
    repeat (2) step();
    // Byte waiting during reset must not be popped until release.
    fq.push_back(8'h55);
    drive_fifo();
    #1;
    chk("rst_pop_held", fifo_pop, 1'b0);
    chk("rst_empty_follows", tx_empty, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    run_idle(2000);
    chk("8n1_pops", obs_pops, 1);
    chk("8n1_dones", obs_dones, 1);

    // 8E1 / 8O1
    set_lcr(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_one(8'hA5, "8e1", 1);
    set_lcr(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_one(8'hA5, "8o1", 1);

    // 5-bit, 1.5 stop
    set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_one(8'h1F, "5n15", 1);

    // Stick parity, 7-bit
    set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    send_one(8'hFF, "7s_e", 1);
    set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    send_one(8'hFF, "7s_o", 1);

    // Back-to-back, 8N1: frame is 160 clks, then one idle clk
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cyc.delete();
    p0 = obs_pops;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    drive_fifo();
    run_idle(2000);
    chk("b2b_pops", obs_pops - p0, 3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap0", pop_cyc[1] - pop_cyc[0], 10 * OS + 1);
      chk("b2b_gap1", pop_cyc[2] - pop_cyc[1], 10 * OS + 1);
    end else begin
      chk("b2b_pop_count", pop_cyc.size(), 3);
    end

    // Break mid-DATA for 40 clks; frame still completes on schedule
    p0 = obs_pops; d0 = obs_dones;
    fq.push_back(8'h3C);
    drive_fifo();
    repeat (OS * 3 + 5) step();
    brk = 1'b1;
    repeat (40) step();
    brk = 1'b0;
    run_idle(2000);
    chk("brk_pops", obs_pops - p0, 1);
    chk("brk_dones", obs_dones - d0, 1);

    // Reset during DATA: frame discarded, next byte sent cleanly
    p0 = obs_pops; d0 = obs_dones;
    fq.push_back(8'h96); fq.push_back(8'h5A);
    drive_fifo();
    repeat (OS * 4 + 3) step();
    rst = 1'b1;
    #1;
    chk("rstmid_tx", tx, 1'b1);
    chk("rstmid_busy", tx_busy, 1'b0);
    chk("rstmid_pop", fifo_pop, 1'b0);
    m_active = 0; m_done = 0; n = 0;
    repeat (3) step();
    rst = 1'b0;
    run_idle(2000);
    chk("rstmid_pops", obs_pops - p0, 2);
    chk("rstmid_dones", obs_dones - d0, 1);

    // Random bytes, random line control (changed mid-frame), sparse baud
    baud_rand = 1;
    lcr_rand = 1;
    for (int k = 0; k < 6; k++) begin
      set_lcr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
      p0 = obs_pops;
      fq.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) fq.push_back(8'($urandom));
      d0 = fq.size();
      drive_fifo();
      run_idle(6000);
      chk("rand_pops", obs_pops - p0, d0);
    end
    baud_rand = 0;
    lcr_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
